// File: rtl/conv_pkg.sv
// Shared definitions for the CONV host-side memory model: default widths,
// bank-select encodings, run-handshake state enum and err bit positions.
package conv_pkg;

    localparam int unsigned DEF_DATAW = 20;
    localparam int unsigned DEF_ADDRW = 12;
    localparam int unsigned NUM_BANKS = 5;

    // Result-memory select encodings driven by CONV on csel.
    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0K0 = 3'b001;
    localparam logic [2:0] CSEL_L0K1 = 3'b010;
    localparam logic [2:0] CSEL_L1K0 = 3'b011;
    localparam logic [2:0] CSEL_L1K1 = 3'b100;
    localparam logic [2:0] CSEL_L2   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    // Sticky error flag bit positions.
    localparam int unsigned ERR_CSEL  = 0;
    localparam int unsigned ERR_ADDR  = 1;
    localparam int unsigned ERR_STATE = 2;
    localparam int unsigned ERR_ARM   = 3;

endpackage

// File: rtl/conv_bank.sv
// 1W1R synchronous RAM with read-before-write on same-address collisions.
// Ports: clk, reset (sync, active-low; clears only the read register),
//        we/waddr/wdata write port, re/raddr read strobe/address,
//        rdata registered read data (holds while re is low).
module conv_bank #(
    parameter int unsigned DATAW = 20,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DATAW-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem [DEPTH];

    // Storage array, never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the array returns the pre-write word on collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/conv_host_mem.sv
// Responder-side model of the CONV accelerator's external interfaces.
// Serves the 64x64 image (iaddr/idata), implements the five csel-selected
// result memories (cwr/crd ports), drives the ready/busy run handshake.
// Ports: clk, reset (sync, active-low); host start, img_we/img_waddr/img_wdata
//        preload; ready/busy handshake; iaddr/idata image read; cwr/caddr_wr/
//        cdata_wr, crd/caddr_rd/cdata_rd, csel result access; done pulse,
//        sticky err[3:0], busy_cycles run counter.
module conv_host_mem
    import conv_pkg::*;
#(
    parameter int unsigned DATAW       = DEF_DATAW,
    parameter int unsigned ADDRW       = DEF_ADDRW,
    parameter int unsigned L0_DEPTH    = 4096,
    parameter int unsigned L1_DEPTH    = 1024,
    parameter int unsigned L2_DEPTH    = 2048,
    parameter int unsigned ARM_TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             img_we,
    input  logic [ADDRW-1:0] img_waddr,
    input  logic [DATAW-1:0] img_wdata,
    output logic             ready,
    input  logic             busy,
    input  logic [ADDRW-1:0] iaddr,
    output logic [DATAW-1:0] idata,
    input  logic             cwr,
    input  logic [ADDRW-1:0] caddr_wr,
    input  logic [DATAW-1:0] cdata_wr,
    input  logic             crd,
    input  logic [ADDRW-1:0] caddr_rd,
    output logic [DATAW-1:0] cdata_rd,
    input  logic [2:0]       csel,
    output logic             done,
    output logic [3:0]       err,
    output logic [31:0]      busy_cycles
);

    localparam int unsigned IMG_DEPTH = 32'(1) << ADDRW;
    localparam int unsigned TW        = $clog2(ARM_TIMEOUT + 1);

    state_t           state, state_nxt;
    logic [TW-1:0]    arm_cnt, arm_cnt_nxt;
    logic [31:0]      bcyc_nxt;
    logic [3:0]       err_nxt;
    logic [2:0]       rd_sel;
    logic             sel_legal, wr_ok, rd_ok;
    logic [DATAW-1:0] bank_rdata [NUM_BANKS];

    // True when addr lies inside the depth of the bank selected by sel.
    function automatic logic addr_ok(input logic [2:0] sel, input logic [ADDRW-1:0] a);
        case (sel)
            CSEL_L0K0, CSEL_L0K1: return 32'(a) < L0_DEPTH;
            CSEL_L1K0, CSEL_L1K1: return 32'(a) < L1_DEPTH;
            CSEL_L2:              return 32'(a) < L2_DEPTH;
            default:              return 1'b0;
        endcase
    endfunction

    assign sel_legal = (csel != CSEL_NONE) && (csel[2:1] != 2'b11);
    assign wr_ok     = addr_ok(csel, caddr_wr);
    assign rd_ok     = addr_ok(csel, caddr_rd);

    // Image memory: host preload in IDLE only, read every cycle.
    conv_bank #(
        .DATAW (DATAW),
        .DEPTH (IMG_DEPTH),
        .AW    (ADDRW)
    ) u_img (
        .clk   (clk),
        .reset (reset),
        .we    (img_we && (state == ST_IDLE)),
        .waddr (img_waddr),
        .wdata (img_wdata),
        .re    (1'b1),
        .raddr (iaddr),
        .rdata (idata)
    );

    // Result banks; bank b answers to csel == b+1.
    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        localparam int unsigned D  = (b < 2) ? L0_DEPTH : (b < 4) ? L1_DEPTH : L2_DEPTH;
        localparam int unsigned AW = $clog2(D);
        logic hit;
        assign hit = (csel == 3'(b + 1));
        conv_bank #(
            .DATAW (DATAW),
            .DEPTH (D),
            .AW    (AW)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (cwr && hit && wr_ok),
            .waddr (caddr_wr[AW-1:0]),
            .wdata (cdata_wr),
            .re    (crd && hit && rd_ok),
            .raddr (caddr_rd[AW-1:0]),
            .rdata (bank_rdata[b])
        );
    end

    // Remembers which bank the last read targeted; NONE forces a zero result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_sel <= CSEL_NONE;
        end else if (crd) begin
            rd_sel <= (sel_legal && rd_ok) ? csel : CSEL_NONE;
        end
    end

    always_comb begin
        cdata_rd = '0;
        case (rd_sel)
            CSEL_L0K0: cdata_rd = bank_rdata[0];
            CSEL_L0K1: cdata_rd = bank_rdata[1];
            CSEL_L1K0: cdata_rd = bank_rdata[2];
            CSEL_L1K1: cdata_rd = bank_rdata[3];
            CSEL_L2:   cdata_rd = bank_rdata[4];
            default:   cdata_rd = '0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            arm_cnt     <= '0;
            ready       <= 1'b0;
            done        <= 1'b0;
            err         <= '0;
            busy_cycles <= '0;
        end else begin
            state       <= state_nxt;
            arm_cnt     <= arm_cnt_nxt;
            ready       <= (state_nxt == ST_ARM);
            done        <= (state_nxt == ST_FIN);
            err         <= err_nxt;
            busy_cycles <= bcyc_nxt;
        end
    end

    // Next-state, arm timer, busy counter and sticky error accumulation.
    // The ARM->RUN edge also counts, since busy was sampled high there.
    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        bcyc_nxt    = busy_cycles;
        err_nxt     = err;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_ARM;
                    arm_cnt_nxt = '0;
                    bcyc_nxt    = '0;
                end
            end
            ST_ARM: begin
                if (busy) begin
                    state_nxt = ST_RUN;
                    bcyc_nxt  = (busy_cycles == '1) ? busy_cycles : busy_cycles + 32'd1;
                end else if (arm_cnt == TW'(ARM_TIMEOUT - 1)) begin
                    state_nxt        = ST_IDLE;
                    err_nxt[ERR_ARM] = 1'b1;
                end else begin
                    arm_cnt_nxt = arm_cnt + TW'(1);
                end
            end
            ST_RUN: begin
                if (busy) begin
                    bcyc_nxt = (busy_cycles == '1) ? busy_cycles : busy_cycles + 32'd1;
                end else begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        if ((cwr || crd) && (csel[2:1] == 2'b11)) begin
            err_nxt[ERR_CSEL] = 1'b1;
        end
        if ((cwr && sel_legal && !wr_ok) || (crd && sel_legal && !rd_ok)) begin
            err_nxt[ERR_ADDR] = 1'b1;
        end
        if (((cwr || crd) && (state != ST_RUN)) || (img_we && (state != ST_IDLE))) begin
            err_nxt[ERR_STATE] = 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_host_mem.sv
// Directed self-checking bench for conv_host_mem.
module tb_conv_host_mem;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        img_we = 1'b0;
    logic [11:0] img_waddr = '0;
    logic [19:0] img_wdata = '0;
    logic        ready;
    logic        busy = 1'b0;
    logic [11:0] iaddr = '0;
    logic [19:0] idata;
    logic        cwr = 1'b0;
    logic [11:0] caddr_wr = '0;
    logic [19:0] cdata_wr = '0;
    logic        crd = 1'b0;
    logic [11:0] caddr_rd = '0;
    logic [19:0] cdata_rd;
    logic [2:0]  csel = CSEL_NONE;
    logic        done;
    logic [3:0]  err;
    logic [31:0] busy_cycles;

    int checks = 0;
    int failures = 0;

    conv_host_mem dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .img_we      (img_we),
        .img_waddr   (img_waddr),
        .img_wdata   (img_wdata),
        .ready       (ready),
        .busy        (busy),
        .iaddr       (iaddr),
        .idata       (idata),
        .cwr         (cwr),
        .caddr_wr    (caddr_wr),
        .cdata_wr    (cdata_wr),
        .crd         (crd),
        .caddr_rd    (caddr_rd),
        .cdata_rd    (cdata_rd),
        .csel        (csel),
        .done        (done),
        .err         (err),
        .busy_cycles (busy_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs read afterwards reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] s, input logic [11:0] a, input logic [19:0] d);
        cwr = 1'b1; csel = s; caddr_wr = a; cdata_wr = d;
        step();
        cwr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] s, input logic [11:0] a);
        crd = 1'b1; csel = s; caddr_rd = a;
        step();
        crd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    int  rcnt;
    bit  saw_done;

    initial begin
        // Reset values
        reset = 1'b0;
        step();
        step();
        chk_eq("rst_ready", 32'(ready), 0);
        chk_eq("rst_done", 32'(done), 0);
        chk_eq("rst_err", 32'(err), 0);
        chk_eq("rst_bcyc", busy_cycles, 0);
        chk_eq("rst_idata", 32'(idata), 0);
        chk_eq("rst_cdata", 32'(cdata_rd), 0);
        reset = 1'b1;

        // Preload image, start a run, read the pixel back
        img_we = 1'b1; img_waddr = 12'h041; img_wdata = 20'h00123;
        step();
        img_we = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk_eq("ready_rise", 32'(ready), 1);
        step();
        step();
        chk_eq("ready_hold", 32'(ready), 1);
        busy = 1'b1; iaddr = 12'h041;
        step();
        chk_eq("ready_fall", 32'(ready), 0);
        chk_eq("idata_041", 32'(idata), 32'h00123);

        // Write then read L0K0
        wr(CSEL_L0K0, 12'h000, 20'hABCDE);
        rd(CSEL_L0K0, 12'h000);
        chk_eq("l0k0_rd", 32'(cdata_rd), 32'hABCDE);
        chk_eq("err_clean", 32'(err), 0);
        step();
        chk_eq("cdata_hold", 32'(cdata_rd), 32'hABCDE);

        // Read-before-write collision on L1K0[0x010]
        wr(CSEL_L1K0, 12'h010, 20'd5);
        wr(CSEL_L1K0, 12'h000, 20'h11111);
        cwr = 1'b1; crd = 1'b1; csel = CSEL_L1K0;
        caddr_wr = 12'h010; cdata_wr = 20'd9; caddr_rd = 12'h010;
        step();
        cwr = 1'b0; crd = 1'b0;
        chk_eq("rbw_old", 32'(cdata_rd), 5);
        rd(CSEL_L1K0, 12'h010);
        chk_eq("rbw_new", 32'(cdata_rd), 9);

        // Last word of L2 and csel=NONE read
        wr(CSEL_L2, 12'h7FF, 20'h55555);
        rd(CSEL_L2, 12'h7FF);
        chk_eq("l2_last", 32'(cdata_rd), 32'h55555);
        rd(CSEL_NONE, 12'h000);
        chk_eq("none_rd", 32'(cdata_rd), 0);
        chk_eq("err_still0", 32'(err), 0);

        // Illegal csel, then out-of-range L1 address
        wr(3'b110, 12'h010, 20'h00007);
        chk_eq("err_csel", 32'(err), 32'b0001);
        wr(CSEL_L1K0, 12'h400, 20'h00007);
        chk_eq("err_addr", 32'(err), 32'b0011);
        rd(CSEL_L1K0, 12'h010);
        chk_eq("l1_010_kept", 32'(cdata_rd), 9);
        rd(CSEL_L1K0, 12'h000);
        chk_eq("l1_000_kept", 32'(cdata_rd), 32'h11111);
        rd(CSEL_L1K0, 12'h400);
        chk_eq("oor_rd_zero", 32'(cdata_rd), 0);

        // End run: done pulse
        busy = 1'b0;
        step();
        chk_eq("done_pulse", 32'(done), 1);
        step();
        chk_eq("done_drop", 32'(done), 0);

        // Clean 100-cycle run
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        busy = 1'b1;
        repeat (100) step();
        busy = 1'b0;
        step();
        chk_eq("done_100", 32'(done), 1);
        chk_eq("bcyc_100", busy_cycles, 100);
        step();
        chk_eq("err_run100", 32'(err), 0);

        // Access outside RUN still performed, flags err[2]
        wr(CSEL_L0K1, 12'h001, 20'h77777);
        chk_eq("err_state", 32'(err), 32'b0100);
        rd(CSEL_L0K1, 12'h001);
        chk_eq("idle_rd", 32'(cdata_rd), 32'h77777);

        // Arm timeout
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        rcnt = ready ? 1 : 0;
        saw_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (ready) rcnt++;
            if (done) saw_done = 1'b1;
        end
        chk_eq("arm_ready_cycles", 32'(rcnt), 256);
        chk_eq("arm_err", 32'(err), 32'b1000);
        chk_eq("arm_ready_low", 32'(ready), 0);
        chk_eq("arm_no_done", 32'(saw_done), 0);

        // Reset in the middle of a run
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        busy = 1'b1;
        step();
        wr(CSEL_L0K1, 12'h005, 20'h2468A);
        rd(CSEL_L0K1, 12'h005);
        step();
        reset = 1'b0;
        step();
        chk_eq("mid_ready", 32'(ready), 0);
        chk_eq("mid_done", 32'(done), 0);
        chk_eq("mid_err", 32'(err), 0);
        chk_eq("mid_bcyc", busy_cycles, 0);
        chk_eq("mid_idata", 32'(idata), 0);
        chk_eq("mid_cdata", 32'(cdata_rd), 0);
        reset = 1'b1;
        repeat (3) step();
        chk_eq("post_ready", 32'(ready), 0);
        chk_eq("post_bcyc", busy_cycles, 0);
        chk_eq("post_idata", 32'(idata), 32'h00123);
        busy = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        busy = 1'b1;
        step();
        rd(CSEL_L0K1, 12'h005);
        chk_eq("retained", 32'(cdata_rd), 32'h2468A);
        chk_eq("retained_err", 32'(err), 0);
        busy = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
